// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: selects, paces, resets and muxes four LED pattern blocks
module led_mode_sequencer #(
    parameter int TICK_DIV       = 4,
    parameter int STEPS_PER_MODE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       auto_en,
    input  logic       btn_next,
    input  logic [7:0] mode0_out,
    input  logic [7:0] mode1_out,
    input  logic [7:0] mode2_out,
    input  logic [7:0] mode3_out,
    output logic [3:0] mode_en,
    output logic       mode_rst,
    output logic [1:0] mode_sel,
    output logic [7:0] led_out
);
    localparam int DW = $clog2(TICK_DIV);
    localparam int SW = (STEPS_PER_MODE > 1) ? $clog2(STEPS_PER_MODE) : 1;
    localparam logic [DW-1:0] DIV_MAX  = DW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_MAX = SW'(STEPS_PER_MODE - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

    state_t        r_state, w_next;
    logic [DW-1:0] r_div;
    logic [SW-1:0] r_step;
    logic [1:0]    r_sel;
    logic          r_btn_prev;
    logic [7:0]    r_led;
    logic          w_run, w_tick, w_adv;
    logic [7:0]    w_pat;

    // next state, step tick and advance request, all from registered state
    always_comb begin
        w_run  = r_state == RUN;
        w_tick = w_run && r_div == DIV_MAX;
        w_adv  = w_run && ((btn_next && !r_btn_prev) || (auto_en && w_tick && r_step == STEP_MAX));
        w_pat  = r_sel == 2'd0 ? mode0_out : r_sel == 2'd1 ? mode1_out : r_sel == 2'd2 ? mode2_out : mode3_out;
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = en ? CLEAR : IDLE;
            CLEAR:   w_next = RUN;
            default: w_next = !en ? IDLE : w_adv ? CLEAR : RUN;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // prescaler, step counter, mode index, button history and LED register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div      <= '0;
            r_step     <= '0;
            r_sel      <= 2'd0;
            r_btn_prev <= 1'b0;
            r_led      <= 8'h00;
        end else begin
            r_div      <= (w_run && w_next == RUN) ? (w_tick ? '0 : r_div + DW'(1)) : '0;
            r_step     <= !w_run ? '0 : !w_tick ? r_step : r_step == STEP_MAX ? '0 : r_step + SW'(1);
            r_sel      <= (w_run && en && w_adv) ? r_sel + 2'd1 : r_sel;
            r_btn_prev <= btn_next;
            r_led      <= w_run ? w_pat : 8'h00;
        end
    end

    assign mode_en  = w_tick ? 4'b0001 << r_sel : 4'b0000;
    assign mode_rst = !w_run;
    assign mode_sel = r_sel;
    assign led_out  = r_led;
endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb_led_mode_sequencer: randomized and directed checks against a run-cycle based model
module tb_led_mode_sequencer;
    localparam int TD  = 4;
    localparam int SPM = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       auto_en = 1'b0;
    logic       btn = 1'b0;
    logic [7:0] mo [4];
    logic [3:0] mode_en;
    logic       mode_rst;
    logic [1:0] mode_sel;
    logic [7:0] led_out;

    int checks = 0;
    int failures = 0;

    // model: phase 0=idle 1=clear 2=run, m_rc = 1-based cycle number within the current run segment
    int         m_ph = 0;
    int         m_rc = 0;
    logic [1:0] m_sel = 2'd0;
    logic       m_prev = 1'b0;
    logic [7:0] m_led = 8'h00;

    led_mode_sequencer #(.TICK_DIV(TD), .STEPS_PER_MODE(SPM)) dut (
        .clk(clk), .reset(reset), .en(en), .auto_en(auto_en), .btn_next(btn),
        .mode0_out(mo[0]), .mode1_out(mo[1]), .mode2_out(mo[2]), .mode3_out(mo[3]),
        .mode_en(mode_en), .mode_rst(mode_rst), .mode_sel(mode_sel), .led_out(led_out)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] exp_vec();
        logic t;
        t = m_ph == 2 && m_rc % TD == 0;
        return {t ? 4'(1 << m_sel) : 4'b0000, m_ph != 2, m_sel, m_led};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {mode_en, mode_rst, mode_sel, led_out};
    endfunction

    task automatic model_reset();
        m_ph = 0; m_rc = 0; m_sel = 2'd0; m_prev = 1'b0; m_led = 8'h00;
    endtask

    // one clock edge; the model steps using the inputs seen just before the edge
    task automatic clk1();
        logic t, ed, au, e;
        logic [7:0] ln;
        t  = m_ph == 2 && m_rc % TD == 0;
        ed = btn && !m_prev;
        au = auto_en && t && ((m_rc / TD) % SPM == 0);
        ln = m_ph == 2 ? mo[m_sel] : 8'h00;
        e  = en;
        m_prev = btn;
        @(posedge clk); #1;
        if (m_ph == 0) begin
            if (e) m_ph = 1;
        end else if (m_ph == 1) begin
            m_ph = 2; m_rc = 1;
        end else if (!e) begin
            m_ph = 0;
        end else if (ed || au) begin
            m_sel = m_sel + 2'd1; m_ph = 1;
        end else begin
            m_rc++;
        end
        m_led = ln;
    endtask

    task automatic goto_mode(input logic [1:0] t);
        for (int k = 0; k < 40 && !(m_sel == t && m_ph == 2); k++) begin
            if (m_ph == 2 && m_sel != t && !m_prev) btn = 1'b1;
            clk1();
            btn = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (dut_vec() !== {4'b0000, 1'b1, 2'd0, 8'h00}) begin failures++; $display("FAIL reset_state got %h exp %h", dut_vec(), {4'b0000, 1'b1, 2'd0, 8'h00}); end
        @(posedge clk); #1;
        checks++;
        if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL reset_hold got %h exp %h", dut_vec(), exp_vec()); end
        reset = 1'b1;
        clk1();
        checks++;
        if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL reset_idle got %h exp %h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_tick();
        auto_en = 1'b0; en = 1'b1;
        clk1();
        checks++;
        if (mode_rst !== 1'b1) begin failures++; $display("FAIL clear_rst got %b exp 1", mode_rst); end
        clk1();
        for (int i = 1; i <= 13; i++) begin
            checks++;
            if (mode_en !== ((i % 4 == 0) ? 4'b0001 : 4'b0000) || mode_rst !== 1'b0) begin
                failures++; $display("FAIL tick_cycle%0d got en=%b rst=%b", i, mode_en, mode_rst);
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL tick_model got %h exp %h", dut_vec(), exp_vec()); end
            clk1();
        end
    endtask

    task automatic test_auto();
        int seen;
        seen = 0;
        auto_en = 1'b1;
        for (int i = 0; i < 90; i++) begin
            if (mode_en != 4'b0000) seen++;
            checks++;
            if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL auto got %h exp %h", dut_vec(), exp_vec()); end
            clk1();
        end
        checks++;
        if (seen < 16) begin failures++; $display("FAIL auto_pulses got %0d exp >=16", seen); end
        auto_en = 1'b0;
    endtask

    task automatic test_button();
        goto_mode(2'd3);
        btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clk1();
            checks++;
            if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL btn_hold got %h exp %h", dut_vec(), exp_vec()); end
        end
        checks++;
        if (mode_sel !== 2'd0) begin failures++; $display("FAIL btn_once got %0d exp 0", mode_sel); end
        btn = 1'b0; clk1(); clk1(); clk1();
        btn = 1'b1; clk1(); btn = 1'b0; clk1();
        checks++;
        if (mode_sel !== 2'd1) begin failures++; $display("FAIL btn_second got %0d exp 1", mode_sel); end
        en = 1'b0; clk1(); clk1();
        btn = 1'b1; clk1(); btn = 1'b0; clk1();
        checks++;
        if (mode_sel !== 2'd1 || mode_rst !== 1'b1) begin failures++; $display("FAIL btn_idle got sel=%0d rst=%b exp 1 1", mode_sel, mode_rst); end
        en = 1'b1; clk1(); clk1();
    endtask

    task automatic test_same_cycle();
        logic [1:0] s;
        auto_en = 1'b1; en = 1'b1; btn = 1'b0;
        for (int k = 0; k < 200 && !(m_ph == 2 && m_rc % TD == 0 && (m_rc / TD) % SPM == 0 && !m_prev); k++) clk1();
        checks++;
        if (!(m_ph == 2 && m_rc % TD == 0)) begin failures++; $display("FAIL same_wait got phase=%0d rc=%0d exp auto tick", m_ph, m_rc); end
        s = m_sel;
        btn = 1'b1; clk1(); btn = 1'b0;
        checks++;
        if (mode_sel !== s + 2'd1) begin failures++; $display("FAIL same_single got %0d exp %0d", mode_sel, s + 2'd1); end
        checks++;
        if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL same_model got %h exp %h", dut_vec(), exp_vec()); end
        auto_en = 1'b0;
        clk1(); clk1(); clk1();
        s = m_sel;
        en = 1'b0; btn = 1'b1; clk1(); btn = 1'b0;
        checks++;
        if (mode_sel !== s || mode_rst !== 1'b1) begin failures++; $display("FAIL en_vs_btn got sel=%0d rst=%b exp %0d 1", mode_sel, mode_rst, s); end
        en = 1'b1; clk1(); clk1();
    endtask

    task automatic test_led();
        auto_en = 1'b0;
        mo[0] = 8'hFF; mo[1] = 8'hFF; mo[2] = 8'hA5; mo[3] = 8'hFF;
        goto_mode(2'd2);
        clk1(); clk1();
        checks++;
        if (led_out !== 8'hA5) begin failures++; $display("FAIL led_mode2 got %h exp a5", led_out); end
        en = 1'b0; clk1();
        checks++;
        if (led_out !== 8'hA5 || mode_rst !== 1'b1) begin failures++; $display("FAIL led_enter_idle got %h rst=%b exp a5 1", led_out, mode_rst); end
        clk1();
        checks++;
        if (led_out !== 8'h00) begin failures++; $display("FAIL led_idle got %h exp 00", led_out); end
        en = 1'b1; clk1(); clk1();
    endtask

    task automatic test_async_reset();
        goto_mode(2'd2);
        clk1(); clk1();
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== {4'b0000, 1'b1, 2'd0, 8'h00}) begin failures++; $display("FAIL async_reset got %h exp %h", dut_vec(), {4'b0000, 1'b1, 2'd0, 8'h00}); end
        #1;
        reset = 1'b1; en = 1'b0;
        clk1();
        checks++;
        if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL after_reset got %h exp %h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            en = $urandom_range(0, 11) != 0;
            if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
            btn = $urandom_range(0, 4) == 0;
            for (int j = 0; j < 4; j++) mo[j] = 8'($urandom);
            clk1();
            checks++;
            if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL random%0d got %h exp %h", i, dut_vec(), exp_vec()); end
        end
        btn = 1'b0;
    endtask

    initial begin
        for (int j = 0; j < 4; j++) mo[j] = 8'h11 * 8'(j + 1);
        test_reset();
        test_tick();
        test_auto();
        test_button();
        test_same_cycle();
        test_led();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
Top-level controller for the combined 4-mode LED design. It owns the four LED pattern blocks (modes 0-3, each 8-bit output with clk/reset/en).
- Selects the active mode and paces it with a divided step-enable pulse.
- Holds the inactive and idle blocks in reset.
- Advances modes on a button edge or automatically after a fixed number of steps.
- Muxes the active block's pattern onto the board LEDs.

Parameters:
TICK_DIV, 4, clock cycles per pattern step (>=2)
STEPS_PER_MODE, 16, steps before automatic advance (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  run enable, level
auto_en  in  1  1 = auto-advance after STEPS_PER_MODE steps
btn_next  in  1  synchronous debounced button; rising edge requests next mode
mode0_out  in  8  pattern from mode 0 block
mode1_out  in  8  pattern from mode 1 block
mode2_out  in  8  pattern from mode 2 block
mode3_out  in  8  pattern from mode 3 block
mode_en  out  4  one-hot step enable to mode blocks, bit i = mode i
mode_rst  out  1  active-high reset to all mode blocks
mode_sel  out  2  current mode index
led_out  out  8  registered LED pattern

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, mode_sel=0, div_cnt=0, step_cnt=0, btn_prev=0, led_out=8'h00, mode_rst=1, mode_en=0.
- States:
  - IDLE: mode_rst=1. Goes to CLEAR when en=1.
  - CLEAR: exactly 1 cycle, mode_rst=1, counters cleared. Goes to RUN.
  - RUN: mode_rst=0.
- RUN transitions, priority high to low:
  1. en=0 -> IDLE; mode_sel retained.
  2. Advance request -> mode_sel = mode_sel+1 mod 4 (3 wraps to 0), then CLEAR.
  3. Otherwise stay in RUN.
- Prescaler: div_cnt counts 0..TICK_DIV-1 in RUN and wraps. It is 0 in IDLE and CLEAR. tick = (state==RUN && div_cnt==TICK_DIV-1).
- First tick falls on the TICK_DIV-th RUN cycle; after that, one tick every TICK_DIV cycles.
- mode_en = tick ? onehot(mode_sel) : 4'b0000. Decoded only from registers; no combinational input-to-output path. Never more than one bit set.
- step_cnt increments on each tick and is cleared in CLEAR.
- Advance request is either of:
  - Button: btn_next=1 && btn_prev=0 while in RUN. btn_prev is registered every cycle in all states. Edges seen in IDLE/CLEAR are discarded, and a held button gives exactly one advance.
  - Auto: auto_en=1 && tick && step_cnt==STEPS_PER_MODE-1.
- Button and auto requests in the same cycle produce a single advance (+1, not +2).
- A tick coinciding with an advance still pulses mode_en for the old mode in that cycle.
- led_out registered each cycle:
  - RUN: the selected modeX_out, 1-cycle latency.
  - IDLE/CLEAR: 8'h00.
- Reset asserted mid-operation returns all state immediately and asynchronously to reset values. mode_sel is not preserved.
- Counter widths: sized by $clog2 of the parameter. No overflow is possible since both counters are bounded.

Test Plan:
- Assert reset=0 mid-RUN in mode 2 -> mode_rst=1, mode_en=0, mode_sel=0, led_out=8'h00 with no clock edge required.
- TICK_DIV=4, STEPS_PER_MODE=4, auto_en=0; raise en -> next edge CLEAR (mode_rst=1), then RUN. mode_en=4'b0001 on RUN cycles 4, 8, 12, ... only.
- auto_en=1, same params -> after the 4th mode_en pulse for mode 0: one CLEAR cycle, then mode_sel=1 with mode_en=4'b0010 pulses. Sequence continues 2, 3, then wraps to 0.
- btn_next held high for 10 cycles in RUN mode 3 -> exactly one advance, mode_sel=0. A second press after release -> mode_sel=1. A press during IDLE -> no change.
- Drive btn_next rising edge and auto-advance condition in the same cycle -> mode_sel +1 only. Drive en=0 and a button edge in the same cycle -> IDLE, mode_sel unchanged.
- Mode 2 active, mode2_out=8'hA5, others 8'hFF -> led_out=8'hA5 one cycle later. Drop en -> led_out=8'h00 one cycle after IDLE is entered.
